// File: rtl/kf8259_in_service_ext.sv
// kf8259_in_service_ext
//   In-service tracker for the KF8259 interrupt controller, generalised to
//   LEVELS interrupt levels. It holds the in-service register (ISR) and the
//   rotating priority base. It applies specific and non-specific EOI,
//   auto-EOI, rotate-on-EOI and set-priority commands. It also publishes the
//   highest-priority unmasked in-service level as a registered one-hot vector.
//
// Parameters
//   LEVELS  number of interrupt levels (power of two, 2..32)
//   ROT_W   level index width, derived from LEVELS
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   interrupt, latch_in_service  level(s) being acknowledged, set strobe
//   auto_eoi                     auto-EOI mode
//   interrupt_special_mask       levels excluded from highest-level resolution
//   eoi_valid/specific/level     EOI command
//   rotate_on_eoi                rotate priority on a successful clear
//   set_priority_valid/level     level to become lowest priority
//   in_service_register          current ISR
//   highest_level_in_service     one-hot highest unmasked ISR bit, or 0
//   priority_base                index of the highest-priority level
//   in_service_count, eoi_error  status outputs (see macro below)
//
// Build option
//   KF8259_IS_STATUS_EN  when defined, in_service_count (ISR popcount) and
//                        eoi_error (invalid EOI pulse) are implemented.
//                        Otherwise both outputs are tied to 0.

module kf8259_in_service_ext #(
  parameter int LEVELS = 8,
  parameter int ROT_W  = $clog2(LEVELS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [LEVELS-1:0]           interrupt,
  input  logic                        latch_in_service,
  input  logic                        auto_eoi,
  input  logic [LEVELS-1:0]           interrupt_special_mask,
  input  logic                        eoi_valid,
  input  logic                        eoi_specific,
  input  logic [ROT_W-1:0]            eoi_level,
  input  logic                        rotate_on_eoi,
  input  logic                        set_priority_valid,
  input  logic [ROT_W-1:0]            set_priority_level,
  output logic [LEVELS-1:0]           in_service_register,
  output logic [LEVELS-1:0]           highest_level_in_service,
  output logic [ROT_W-1:0]            priority_base,
  output logic [$clog2(LEVELS+1)-1:0] in_service_count,
  output logic                        eoi_error
);

  localparam int CNT_W = $clog2(LEVELS+1);

  function automatic logic [LEVELS-1:0] rot_r(input logic [LEVELS-1:0] v,
                                              input logic [ROT_W-1:0]  s);
    logic [2*LEVELS-1:0] d;
    d = {v, v} >> s;
    return d[LEVELS-1:0];
  endfunction

  function automatic logic [LEVELS-1:0] rot_l(input logic [LEVELS-1:0] v,
                                              input logic [ROT_W-1:0]  s);
    logic [2*LEVELS-1:0] d;
    d = {v, v} << s;
    return d[2*LEVELS-1:LEVELS];
  endfunction

  function automatic logic [LEVELS-1:0] lsb(input logic [LEVELS-1:0] v);
    return v & (~v + LEVELS'(1));
  endfunction

  // Index of a one-hot vector. Callers pass a one-hot value (or 0).
  function automatic logic [ROT_W-1:0] oh2idx(input logic [LEVELS-1:0] v);
    logic [ROT_W-1:0] r;
    r = '0;
    for (int i = 0; i < LEVELS; i++)
      if (v[i]) r = r | ROT_W'(i);
    return r;
  endfunction

  logic [LEVELS-1:0] isr_q, highest_q, aeoi_q;
  logic [ROT_W-1:0]  base_q;

  logic [LEVELS-1:0] eoi_target, clr, isr_d, highest_d, aeoi_d;
  logic [ROT_W-1:0]  base_d, eoi_idx;
  logic              eoi_ok;

  always_comb begin
    eoi_target = eoi_specific ? (LEVELS'(1) << eoi_level) : highest_q;
    eoi_idx    = eoi_specific ? eoi_level : oh2idx(highest_q);
    // An EOI is only valid if it names something actually in service. An
    // invalid one is dropped entirely, so it can neither clear nor rotate.
    eoi_ok     = eoi_valid & (eoi_specific ? isr_q[eoi_level] : |highest_q);

    clr   = (eoi_ok ? eoi_target : '0) | aeoi_q;
    // Applying the set after the clear lets a same-cycle latch win.
    isr_d = (isr_q & ~clr) | (latch_in_service ? interrupt : '0);

    // Precedence: set-priority, then explicit EOI rotation, then auto-EOI.
    // Index arithmetic wraps naturally because LEVELS is a power of two.
    base_d = base_q;
    if (set_priority_valid)
      base_d = set_priority_level + ROT_W'(1);
    else if (rotate_on_eoi && eoi_ok)
      base_d = eoi_idx + ROT_W'(1);
    else if (rotate_on_eoi && |aeoi_q)
      base_d = oh2idx(lsb(aeoi_q)) + ROT_W'(1);

    // Rotate so that base sits at bit 0. Take the lowest set bit, then
    // rotate back.
    highest_d = rot_l(lsb(rot_r(isr_d & ~interrupt_special_mask, base_d)), base_d);

    aeoi_d = (auto_eoi && latch_in_service) ? interrupt : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      isr_q     <= '0;
      highest_q <= '0;
      aeoi_q    <= '0;
      base_q    <= '0;
    end else begin
      isr_q     <= isr_d;
      highest_q <= highest_d;
      aeoi_q    <= aeoi_d;
      base_q    <= base_d;
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = highest_q;
  assign priority_base            = base_q;

`ifdef KF8259_IS_STATUS_EN
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  function automatic logic [CNT_W-1:0] popcnt(input logic [LEVELS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LEVELS; i++)
      c = c + CNT_W'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= popcnt(isr_d);
      err_q <= eoi_valid & ~eoi_ok;
    end
  end

  assign in_service_count = cnt_q;
  assign eoi_error        = err_q;
`else
  assign in_service_count = '0;
  assign eoi_error        = 1'b0;
`endif

endmodule
